// File: rtl/tiny_fpga_fabric_if.sv
// Fabric pin bundle: parallel bitstream, primary inputs A-D and output Z.
//   master : drives prog_in, A, B, C, D; observes Z
//   slave  : the fabric; observes prog_in, A-D; drives Z
interface tiny_fpga_fabric_if;
  logic [115:0] prog_in;
  logic         A;
  logic         B;
  logic         C;
  logic         D;
  logic         Z;

  modport master (output prog_in, output A, output B, output C, output D, input Z);
  modport slave  (input prog_in, input A, input B, input C, input D, output Z);
endinterface

// File: rtl/tiny_fpga_fabric.sv
// Minimal programmable fabric: four 4-input LUT cells with forward-only
// routing and an OR-combined output pin Z.
//   clk   : rising-edge clock
//   reset : async active-high; forces Z low, clears cell flops, and opens
//           the bitstream load window (cfg captured every edge while high)
//   bus   : slave modport of tiny_fpga_fabric_if (prog_in, A-D in, Z out)
// Optional build macro TINY_FPGA_CELL_FF_EN adds a per-cell output flop
// selected by the cell's ff_en bit; without it every cell is combinational.
module tiny_fpga_fabric (
  input  logic                clk,
  input  logic                reset,
  tiny_fpga_fabric_if.slave   bus
);

  localparam int unsigned NCELL      = 4;
  localparam int unsigned NIN        = 4;
  localparam int unsigned CFG_W      = 116;
  localparam int unsigned LUT_W      = 16;
  localparam int unsigned ROUTE_W    = 8;
  localparam int unsigned CCFG_W     = 5;
  localparam int unsigned LUT_BASE   = 52;
  localparam int unsigned ROUTE_BASE = 20;
  localparam int unsigned BIT_FF_EN  = 4;
  localparam int unsigned BIT_INV    = 3;
  localparam int unsigned BIT_ZDRV   = 2;
  localparam int unsigned IDX_W      = 7;

  logic [CFG_W-1:0] cfg_q;
  logic [CFG_W-1:0] cfg_d;
  logic [NIN-1:0]   pins_c;
  logic [NCELL-1:0] val_c;
  logic [NCELL-1:0] o_c;
  logic [NCELL-1:0] zen_c;

  assign pins_c = {bus.D, bus.C, bus.B, bus.A};

  // Bitstream load window: capture while reset is high, hold otherwise.
  assign cfg_d = reset ? bus.prog_in : cfg_q;

  always_ff @(posedge clk) begin
    cfg_q <= cfg_d;
  end

`ifdef TINY_FPGA_CELL_FF_EN
  logic [NCELL-1:0] ff_q;
  logic [NCELL-1:0] ff_d;

  // Post-inversion cell values; ff_en picks whether O uses this flop.
  assign ff_d = val_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q <= '0;
    end else begin
      ff_q <= ff_d;
    end
  end
`endif

  // Cell evaluation in index order so cell i only sees outputs of cells < i.
  always_comb begin
    logic [NCELL-1:0] o_v;
    logic [NIN-1:0]   in_v;
    logic [1:0]       sel_v;
    logic [IDX_W-1:0] idx_v;

    val_c = '0;
    zen_c = '0;
    o_v   = '0;
    in_v  = '0;
    sel_v = '0;
    idx_v = '0;

    for (int unsigned i = 0; i < NCELL; i++) begin
      in_v = '0;
      for (int unsigned k = 0; k < NIN; k++) begin
        idx_v = IDX_W'(ROUTE_BASE + ROUTE_W * i + 2 * k);
        sel_v = cfg_q[idx_v +: 2];
        case (sel_v)
          2'b00:   in_v[k] = pins_c[k];
          2'b01:   in_v[k] = (k < i) ? o_v[k] : 1'b0;
          2'b10:   in_v[k] = 1'b0;
          default: in_v[k] = 1'b1;
        endcase
      end

      idx_v    = IDX_W'(LUT_BASE + LUT_W * i + 32'(in_v));
      val_c[i] = cfg_q[idx_v];
      idx_v    = IDX_W'(CCFG_W * i + BIT_INV);
      val_c[i] = val_c[i] ^ cfg_q[idx_v];
      o_v[i]   = val_c[i];

`ifdef TINY_FPGA_CELL_FF_EN
      idx_v = IDX_W'(CCFG_W * i + BIT_FF_EN);
      if (cfg_q[idx_v]) begin
        o_v[i] = ff_q[i];
      end
`endif

      idx_v    = IDX_W'(CCFG_W * i + BIT_ZDRV);
      zen_c[i] = cfg_q[idx_v];
    end

    o_c = o_v;
  end

  // Z is forced low asynchronously while reset is asserted.
  assign bus.Z = reset ? 1'b0 : |(o_c & zen_c);

endmodule

// File: tb/tb_tiny_fpga_fabric.sv
module tb_tiny_fpga_fabric;

`ifdef TINY_FPGA_CELL_FF_EN
  localparam bit FF_BUILD = 1'b1;
`else
  localparam bit FF_BUILD = 1'b0;
`endif

  typedef struct {
    string name;
    logic  z;
  } exp_t;

  logic clk;
  logic reset;

  tiny_fpga_fabric_if bus ();

  tiny_fpga_fabric dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  exp_t         exp_q[$];
  event         smp_ev;
  int           checks;
  int           failures;

  logic [115:0] m_cfg;
  logic [3:0]   m_ff;
  logic [3:0]   m_pins;

  // Reference: apply the routing/LUT/invert/z_drive rules cell by cell.
  function automatic logic model_z(input logic [115:0] cfg, input logic [3:0] pins,
                                   input logic [3:0] ff, input logic rst,
                                   output logic [3:0] val);
    logic [3:0] o;
    logic       z;
    logic       b;
    int         idx;
    int         sel;
    o   = '0;
    val = '0;
    z   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = 0;
      for (int k = 0; k < 4; k++) begin
        sel = int'(cfg[20 + 8 * i + 2 * k]) + 2 * int'(cfg[21 + 8 * i + 2 * k]);
        case (sel)
          0:       b = pins[k];
          1:       b = (k < i) ? o[k] : 1'b0;
          2:       b = 1'b0;
          default: b = 1'b1;
        endcase
        if (b) idx += (1 << k);
      end
      val[i] = cfg[52 + 16 * i + idx] ^ cfg[5 * i + 3];
      o[i]   = (FF_BUILD && cfg[5 * i + 4]) ? ff[i] : val[i];
      if (cfg[5 * i + 2]) z = z | o[i];
    end
    return rst ? 1'b0 : z;
  endfunction

  function automatic logic [115:0] mk_cfg(input logic [63:0] luts, input logic [31:0] routes,
                                          input logic [19:0] ccfg);
    return {luts, routes, ccfg};
  endfunction

  // Monitor: each sample event pops one expectation and compares Z.
  initial begin
    exp_t e;
    forever begin
      @(smp_ev);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s: sample with empty expectation queue, Z=%b", "queue", bus.Z);
      end else begin
        e = exp_q.pop_front();
        if (bus.Z !== e.z) begin
          failures++;
          $display("FAIL %s: Z=%b expected=%b at t=%0t", e.name, bus.Z, e.z, $time);
        end
      end
    end
  end

  task automatic set_pins(input logic [3:0] p);
    bus.A  = p[0];
    bus.B  = p[1];
    bus.C  = p[2];
    bus.D  = p[3];
    m_pins = p;
  endtask

  task automatic expect_z(input string nm, input logic e);
    #1;
    exp_q.push_back('{nm, e});
    -> smp_ev;
    #1;
  endtask

  task automatic expect_model(input string nm);
    logic [3:0] v;
    logic       e;
    e = model_z(m_cfg, m_pins, m_ff, reset, v);
    expect_z(nm, e);
  endtask

  // One clock: advance model state at the edge, return on the falling edge.
  task automatic tick();
    logic [3:0] v;
    logic       unused_z;
    unused_z = model_z(m_cfg, m_pins, m_ff, 1'b0, v);
    @(posedge clk);
    if (reset) begin
      m_ff  = '0;
      m_cfg = bus.prog_in;
    end else begin
      m_ff = v;
    end
    @(negedge clk);
  endtask

  task automatic async_reset();
    reset = 1'b1;
    m_ff  = '0;
  endtask

  task automatic load(input logic [115:0] cfg, input int edges);
    async_reset();
    bus.prog_in = cfg;
    set_pins(4'b0000);
    expect_z("reset_z", 1'b0);
    for (int n = 0; n < edges; n++) tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [115:0] rc;
    checks      = 0;
    failures    = 0;
    m_ff        = '0;
    m_pins      = '0;
    reset       = 1'b1;
    bus.prog_in = '0;
    set_pins(4'b0000);

    // AND gate on cell0.
    load(mk_cfg({16'h0, 16'h0, 16'h0, 16'h8888}, 32'h0, 20'h00004), 2);
    set_pins(4'b0011); expect_z("and_11", 1'b1);
    set_pins(4'b0001); expect_z("and_10", 1'b0);

    // XNOR via cell0 XOR feeding cell1 inverter.
    load(mk_cfg({16'h0, 16'h0, 16'h5555, 16'h6666}, 32'h0000_0100, 20'h00080), 2);
    set_pins(4'b0001); expect_z("xnor_10", 1'b0);
    set_pins(4'b0011); expect_z("xnor_11", 1'b1);

    // Registered AND cell, then async reset clears the flop.
    load(mk_cfg({16'h0, 16'h0, 16'h0, 16'h8888}, 32'h0, 20'h00014), 2);
    set_pins(4'b0011); expect_z("reg_pre_edge", FF_BUILD ? 1'b0 : 1'b1);
    tick();            expect_z("reg_post_edge", 1'b1);
    async_reset();     expect_z("reg_async_rst", 1'b0);
    reset = 1'b0;      expect_z("reg_ff_cleared", FF_BUILD ? 1'b0 : 1'b1);
    tick();            expect_z("reg_recapture", 1'b1);

    // Forward-only routing: cell0 input1 selecting O[1] reads 0.
    load(mk_cfg({16'h0, 16'h0, 16'hFFFF, 16'h8888}, 32'h0000_0004, 20'h00004), 2);
    set_pins(4'b0011); expect_z("fwd_only", 1'b0);

    // Reset mid-operation, reload as OR gate.
    load(mk_cfg({16'h0, 16'h0, 16'h0, 16'h8888}, 32'h0, 20'h00004), 2);
    set_pins(4'b0011); expect_z("mid_pre", 1'b1);
    async_reset();     expect_z("mid_async", 1'b0);
    bus.prog_in = mk_cfg({16'h0, 16'h0, 16'h0, 16'hEEEE}, 32'h0, 20'h00004);
    tick();
    reset = 1'b0;
    set_pins(4'b0001); expect_z("mid_or_10", 1'b1);
    set_pins(4'b0000); expect_z("mid_or_00", 1'b0);

    // Constant-1 routing into cell2 with and without inversion.
    load(mk_cfg({16'h0, 16'h8000, 16'h0, 16'h0}, 32'h00FF_0000, 20'h03000), 1);
    set_pins(4'b0000); expect_z("const_inv", 1'b0);
    load(mk_cfg({16'h0, 16'h8000, 16'h0, 16'h0}, 32'h00FF_0000, 20'h01000), 1);
    set_pins(4'b1111); expect_z("const_noinv", 1'b1);

    // Randomized configurations and pin sequences against the model.
    for (int it = 0; it < 40; it++) begin
      rc = {20'($urandom), $urandom, $urandom, $urandom};
      load(rc, int'($urandom_range(1, 2)));
      for (int cyc = 0; cyc < 8; cyc++) begin
        set_pins(4'($urandom));
        expect_model("rand");
        if ($urandom_range(0, 7) == 0) begin
          async_reset();
          expect_model("rand_rst");
          bus.prog_in = {20'($urandom), $urandom, $urandom, $urandom};
          tick();
          reset = 1'b0;
          expect_model("rand_reload");
        end else begin
          tick();
          expect_model("rand_edge");
        end
      end
    end

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
